// File: rtl/pll_lock_supervisor.sv
// Purpose: brings the rPLL from power-up to a qualified lock, then releases the downstream reset.
// Latency: outputs are registered and decoded from the next state; pll_lock reaches the FSM through a 2-FF synchronizer.
// Backpressure: none; relock_req is a single-cycle pulse that is only acted on in RUN or FAIL.
//
// Ports:
//   clk          PLL reference clock; the PLL output is not trusted before lock
//   reset_n      asynchronous active-low reset
//   pll_lock     rPLL LOCK, asynchronous to clk
//   relock_req   single-cycle pulse requesting a full PLL restart
//   pll_reset    rPLL RESET, active high
//   sys_reset_n  downstream reset, active low, registered
//   locked       high only in RUN
//   fail         high only in FAIL
//   retry_count  lock timeouts in the current bring-up attempt, saturating at MAX_RETRY
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOSS_FILTER    = 4,
  parameter int MAX_RETRY      = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_count
);

  // The shared counter must hold the largest terminal value, and never
  // drops below 17 bits so the default timeout always fits.
  localparam int MAX_TW  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAX_SH  = (PLL_RST_CYCLES > LOSS_FILTER) ? PLL_RST_CYCLES : LOSS_FILTER;
  localparam int MAX_ALL = (MAX_TW > MAX_SH) ? MAX_TW : MAX_SH;
  localparam int NEED_W  = $clog2(MAX_ALL + 1);
  localparam int CNT_W   = (NEED_W > 17) ? NEED_W : 17;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
  localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       retry_nxt;
  logic             lock_meta, lock_s;

  // LOCK comes from the analogue PLL with no timing relation to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    retry_nxt = retry_count;
    case (state)
      S_RST_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins over a retry.
        if (lock_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (retry_count == RETRY_MAX) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_RST_PLL;
            retry_nxt = retry_count + 3'd1;
          end
        end
      end
      S_STABLE: begin
        // Any low sample restarts the wait with a fresh timeout, no retry charged.
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // Counter tracks consecutive low samples; a single high clears it.
        if (lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOSS_LAST) begin
          state_nxt = S_RST_PLL;
          cnt_nxt   = '0;
          retry_nxt = 3'd0;
        end
        if (relock_req) begin
          state_nxt = S_RST_PLL;
          cnt_nxt   = '0;
          retry_nxt = 3'd0;
        end
      end
      S_FAIL: begin
        cnt_nxt = '0;
        if (relock_req) begin
          state_nxt = S_RST_PLL;
          retry_nxt = 3'd0;
        end
      end
      default: begin
        state_nxt = S_RST_PLL;
        cnt_nxt   = '0;
        retry_nxt = 3'd0;
      end
    endcase
  end

  // Outputs come from state_nxt so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RST_PLL;
      cnt         <= '0;
      retry_count <= 3'd0;
      pll_reset   <= 1'b1;
      sys_reset_n <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      pll_reset   <= (state_nxt == S_RST_PLL) || (state_nxt == S_FAIL);
      sys_reset_n <= (state_nxt == S_RUN);
      locked      <= (state_nxt == S_RUN);
      fail        <= (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose: self-checking bench for pll_lock_supervisor with small parameters.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Backpressure: none; expected outputs are queued as each cycle is driven and popped when sampled.
module tb_pll_lock_supervisor;

  localparam int P_RST   = 4;
  localparam int P_TO    = 32;
  localparam int P_STB   = 8;
  localparam int P_LOSS  = 3;
  localparam int P_RETRY = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       locked;
  logic       fail;
  logic [2:0] retry_count;
  logic [6:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       lock;
    logic       relock;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t       vtbl[$];
  logic [6:0] sb[$];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STB),
    .LOSS_FILTER   (P_LOSS),
    .MAX_RETRY     (P_RETRY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .sys_reset_n(sys_reset_n),
    .locked     (locked),
    .fail       (fail),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  assign obs = {pll_reset, sys_reset_n, locked, fail, retry_count};

  // Packs {pll_reset, sys_reset_n, locked, fail, retry_count}.
  function automatic logic [6:0] o(logic pr, logic sr, logic lk, logic fl, logic [2:0] rc);
    return {pr, sr, lk, fl, rc};
  endfunction

  function automatic void add_vec(logic lock, logic relock, int n, logic [6:0] e);
    vec_t v;
    v.lock   = lock;
    v.relock = relock;
    v.n      = n;
    v.exp    = e;
    vtbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 'h%0h required 'h%0h", name, act, exp);
    end
  endtask

  // Mimics a PLL that locks as soon as its RESET is released; counts edges
  // from reset_n release until sys_reset_n rises.
  task automatic bring_up(input string tag);
    int edges;
    int fall_edge;
    bit done;
    edges     = 0;
    fall_edge = 0;
    done      = 1'b0;
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (!pll_reset && fall_edge == 0) begin
        fall_edge = edges;
        pll_lock  = 1'b1;
      end
      @(negedge clk);
      if (sys_reset_n) done = 1'b1;
    end
    check($sformatf("%s_released", tag), 32'(done), 32'd1);
    check($sformatf("%s_pll_reset_fall_edge", tag), fall_edge, P_RST);
    check($sformatf("%s_release_edge", tag), edges, P_RST + 2 + 1 + P_STB);
    check($sformatf("%s_run_outputs", tag), 32'(obs), 32'(o(1'b0, 1'b1, 1'b1, 1'b0, 3'd0)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] e;
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;

    // Row k of the trace: edge k updates the DUT, inputs for cycle k follow at +1.
    // A pll_lock change after edge k is acted on by the FSM at edge k+3.
    add_vec(0, 0,  3, o(1, 0, 0, 0, 0)); // k1-3    RST_PLL
    add_vec(1, 0, 11, o(0, 0, 0, 0, 0)); // k4-14   WAIT, STABLE from edge 7
    add_vec(1, 0,  5, o(0, 1, 1, 0, 0)); // k15-19  RUN at edge 15
    add_vec(0, 0,  2, o(0, 1, 1, 0, 0)); // k20-21  2-cycle glitch, filtered
    add_vec(1, 0,  6, o(0, 1, 1, 0, 0)); // k22-27
    add_vec(0, 0,  5, o(0, 1, 1, 0, 0)); // k28-32  real loss, acted on at edge 33
    add_vec(0, 0,  4, o(1, 0, 0, 0, 0)); // k33-36  RST_PLL after loss
    add_vec(0, 0, 32, o(0, 0, 0, 0, 0)); // k37-68  WAIT, timeout at edge 69
    add_vec(0, 0,  4, o(1, 0, 0, 0, 1)); // k69-72  retry 1
    add_vec(0, 0, 32, o(0, 0, 0, 0, 1)); // k73-104
    add_vec(0, 0,  4, o(1, 0, 0, 0, 2)); // k105-108 retry 2
    add_vec(0, 0, 32, o(0, 0, 0, 0, 2)); // k109-140
    add_vec(0, 0, 10, o(1, 0, 0, 1, 2)); // k141-150 FAIL
    add_vec(0, 1,  1, o(1, 0, 0, 1, 2)); // k151     relock in FAIL
    add_vec(0, 0,  4, o(1, 0, 0, 0, 0)); // k152-155 RST_PLL
    add_vec(0, 0,  1, o(0, 0, 0, 0, 0)); // k156     WAIT
    add_vec(0, 1,  1, o(0, 0, 0, 0, 0)); // k157     relock in WAIT ignored
    add_vec(0, 0,  2, o(0, 0, 0, 0, 0)); // k158-159
    add_vec(1, 0,  5, o(0, 0, 0, 0, 0)); // k160-164 STABLE from edge 163
    add_vec(0, 0,  1, o(0, 0, 0, 0, 0)); // k165     one low aborts STABLE
    add_vec(1, 0, 11, o(0, 0, 0, 0, 0)); // k166-176 STABLE again from edge 169
    add_vec(1, 0,  5, o(0, 1, 1, 0, 0)); // k177-181 RUN at edge 177
    add_vec(1, 1,  1, o(0, 1, 1, 0, 0)); // k182     relock in RUN
    add_vec(1, 0,  4, o(1, 0, 0, 0, 0)); // k183-186 RST_PLL
    add_vec(1, 0,  4, o(0, 0, 0, 0, 0)); // k187-190 WAIT, STABLE from edge 188

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs), 32'(o(1, 0, 0, 0, 0)));
    reset_n = 1'b1;

    foreach (vtbl[r]) begin
      for (int i = 0; i < vtbl[r].n; i++) begin
        @(posedge clk);
        #1;
        pll_lock   = vtbl[r].lock;
        relock_req = vtbl[r].relock;
        sb.push_back(vtbl[r].exp);
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("vec%0d_cyc%0d", r, i), 32'(obs), 32'(e));
      end
    end
    relock_req = 1'b0;

    // Asynchronous reset in the middle of STABLE: outputs drop without a clock edge.
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_stable", 32'(obs), 32'(o(1, 0, 0, 0, 0)));
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    check("held_reset_mid_stable", 32'(obs), 32'(o(1, 0, 0, 0, 0)));
    reset_n = 1'b1;
    bring_up("restart_after_stable");

    // Asynchronous reset in RUN.
    repeat (3) @(negedge clk);
    check("run_before_reset", 32'(obs), 32'(o(0, 1, 1, 0, 0)));
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_run", 32'(obs), 32'(o(1, 0, 0, 0, 0)));
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bring_up("restart_after_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
